// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle main control FSM (master) and the
// datapath / memory side (slave).
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       iord;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [1:0] alu_op;
  logic       mem_err;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst,
           alu_src_a, alu_src_b, pc_src, alu_op, mem_err
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst,
           alu_src_a, alu_src_b, pc_src, alu_op, mem_err
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS32 main control FSM with memory-wait timeout.
// Define ADDI_EN to add the ADDIEX/ADDIWB path for opcode 001000.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int STATE_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_multicycle_ctrl_if.master bus,
  output logic [STATE_W-1:0]    state
);
  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXECUTE = STATE_W'(6),
    ALUWB   = STATE_W'(7),
    BEQ     = STATE_W'(8),
`ifdef ADDI_EN
    ADDIEX  = STATE_W'(9),
    ADDIWB  = STATE_W'(10),
`endif
    JUMP    = STATE_W'(11)
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             err_reg;
  logic             ready, wait_state, timeout_hit;
  logic             pc_write, branch;

  // The abort cycle after a timeout never accepts mem_ready, so nothing is written.
  always_comb begin
    ready       = bus.mem_ready & ~err_reg;
    wait_state  = (state_reg == FETCH) || (state_reg == MEMRD) || (state_reg == MEMWR);
    timeout_hit = (MEM_TIMEOUT != 0) && wait_state && !bus.mem_ready && !err_reg &&
                  (wait_cnt_reg == CNT_LAST);
  end

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:   state_next = ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BEQ;
          OP_J:         state_next = JUMP;
`ifdef ADDI_EN
          OP_ADDI:      state_next = ADDIEX;
`else
          // 001000 is an unknown opcode here and drops back to FETCH
`endif
          default:      state_next = FETCH;
        endcase
      end
      MEMADR: begin
        if (bus.opcode == OP_LW)      state_next = MEMRD;
        else if (bus.opcode == OP_SW) state_next = MEMWR;
        else                          state_next = FETCH;
      end
      MEMRD:   state_next = ready ? MEMWB : MEMRD;
      MEMWB:   state_next = FETCH;
      MEMWR:   state_next = ready ? FETCH : MEMWR;
      EXECUTE: state_next = ALUWB;
      ALUWB:   state_next = FETCH;
      BEQ:     state_next = FETCH;
`ifdef ADDI_EN
      ADDIEX:  state_next = ADDIWB;
      ADDIWB:  state_next = FETCH;
`endif
      JUMP:    state_next = FETCH;
      default: state_next = FETCH;
    endcase
    if (timeout_hit) state_next = FETCH;
  end

  always_comb begin
    pc_write       = 1'b0;
    branch         = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.pc_src     = 2'b00;
    case (state_reg)
      FETCH: begin
        bus.alu_src_b = 2'b01;
        bus.ir_write  = ready;
        pc_write      = ready;
      end
      DECODE:  bus.alu_src_b = 2'b11;
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      MEMRD:   bus.iord = 1'b1;
      MEMWB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
      end
      MEMWR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
      end
      EXECUTE: bus.alu_src_a = 1'b1;
      ALUWB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
      end
      BEQ: begin
        bus.alu_src_a = 1'b1;
        bus.pc_src    = 2'b01;
        branch        = 1'b1;
      end
`ifdef ADDI_EN
      ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      ADDIWB:  bus.reg_write = 1'b1;
`endif
      JUMP: begin
        bus.pc_src = 2'b10;
        pc_write   = 1'b1;
      end
      default: ;
    endcase

    bus.pc_en   = pc_write | (branch & bus.zero);
    bus.mem_err = err_reg;
    // ALU control registers alu_op, so it is decoded one state ahead.
    case (state_next)
      EXECUTE: bus.alu_op = 2'b10;
      BEQ:     bus.alu_op = 2'b01;
      default: bus.alu_op = 2'b00;
    endcase
    state = state_reg;

    if (reset) begin
      bus.pc_en      = 1'b0;
      bus.ir_write   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.iord       = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.pc_src     = 2'b00;
      bus.alu_op     = 2'b00;
      bus.mem_err    = 1'b0;
      state          = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= FETCH;
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= timeout_hit;
      if (timeout_hit || err_reg || (state_next != state_reg))
        wait_cnt_reg <= '0;
      else if (wait_state && !bus.mem_ready)
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for mips_multicycle_ctrl (MEM_TIMEOUT=4);
// one line per applied cycle, expected values written by hand.
module tb_mips_multicycle_ctrl;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100;
  localparam logic [5:0] JP = 6'b000010;
  localparam logic [5:0] AD = 6'b001000;
  localparam logic [5:0] XX = 6'b111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] state;

  mips_multicycle_ctrl_if bus();

  mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  always #5 clk = ~clk;

  // en = {pc_en, ir_write, mem_write, reg_write}; sel = {iord, mem_to_reg, reg_dst, alu_src_a}
  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       rdy;
    logic [3:0] st;
    logic [3:0] en;
    logic [3:0] sel;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       err;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input int rst, input logic [5:0] op, input int z, input int rdy,
                              input int st, input logic [3:0] en, input logic [3:0] sel,
                              input logic [1:0] b, input logic [1:0] pc, input logic [1:0] aop,
                              input int err);
    mk = '{1'(rst), op, 1'(z), 1'(rdy), 4'(st), en, sel, b, pc, aop, 1'(err)};
  endfunction

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  task automatic step(input vec_t v, input string tag, input int idx);
    logic [18:0] got, want;
    @(negedge clk);
    reset         = v.rst;
    bus.opcode    = v.op;
    bus.zero      = v.z;
    bus.mem_ready = v.rdy;
    #1;
    got  = {state, bus.pc_en, bus.ir_write, bus.mem_write, bus.reg_write,
            bus.iord, bus.mem_to_reg, bus.reg_dst, bus.alu_src_a,
            bus.alu_src_b, bus.pc_src, bus.alu_op, bus.mem_err};
    want = {v.st, v.en, v.sel, v.src_b, v.pc_src, v.alu_op, v.err};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d]: got st=%0d en=%b sel=%b b=%b pc=%b op=%b err=%b, want st=%0d en=%b sel=%b b=%b pc=%b op=%b err=%b",
               tag, idx, got[18:15], got[14:11], got[10:7], got[6:5], got[4:3], got[2:1], got[0],
               want[18:15], want[14:11], want[10:7], want[6:5], want[4:3], want[2:1], want[0]);
    end else begin
      $display("%s[%0d] rst=%0d op=%b rdy=%0d st=%0d en=%b ok", tag, idx, v.rst, v.op, v.rdy,
               got[18:15], got[14:11]);
    end
  endtask

  initial begin
    bus.opcode    = LW;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    // reset held 3 cycles with mem_ready=1
    for (int i = 0; i < 3; i++) add(mk(1, LW, 0, 1, 0, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 0));
    // LW: 0,1,2,3,4
    add(mk(0, LW, 0, 1, 0, 4'b1100, 4'b0000, 2'b01, 2'b00, 2'b00, 0));
    add(mk(0, LW, 0, 1, 1, 4'b0000, 4'b0000, 2'b11, 2'b00, 2'b00, 0));
    add(mk(0, LW, 0, 1, 2, 4'b0000, 4'b0001, 2'b10, 2'b00, 2'b00, 0));
    add(mk(0, LW, 0, 1, 3, 4'b0000, 4'b1000, 2'b00, 2'b00, 2'b00, 0));
    add(mk(0, LW, 0, 1, 4, 4'b0001, 4'b0100, 2'b00, 2'b00, 2'b00, 0));
    // R-type with one fetch stall
    add(mk(0, RT, 0, 0, 0, 4'b0000, 4'b0000, 2'b01, 2'b00, 2'b00, 0));
    add(mk(0, RT, 0, 1, 0, 4'b1100, 4'b0000, 2'b01, 2'b00, 2'b00, 0));
    add(mk(0, RT, 0, 1, 1, 4'b0000, 4'b0000, 2'b11, 2'b00, 2'b10, 0));
    add(mk(0, RT, 0, 1, 6, 4'b0000, 4'b0001, 2'b00, 2'b00, 2'b00, 0));
    add(mk(0, RT, 0, 1, 7, 4'b0001, 4'b0010, 2'b00, 2'b00, 2'b00, 0));
    // BEQ taken, then not taken
    add(mk(0, BQ, 1, 1, 0, 4'b1100, 4'b0000, 2'b01, 2'b00, 2'b00, 0));
    add(mk(0, BQ, 1, 1, 1, 4'b0000, 4'b0000, 2'b11, 2'b00, 2'b01, 0));
    add(mk(0, BQ, 1, 1, 8, 4'b1000, 4'b0001, 2'b00, 2'b01, 2'b00, 0));
    add(mk(0, BQ, 0, 1, 0, 4'b1100, 4'b0000, 2'b01, 2'b00, 2'b00, 0));
    add(mk(0, BQ, 0, 1, 1, 4'b0000, 4'b0000, 2'b11, 2'b00, 2'b01, 0));
    add(mk(0, BQ, 0, 1, 8, 4'b0000, 4'b0001, 2'b00, 2'b01, 2'b00, 0));
    // Jump
    add(mk(0, JP, 0, 1, 0, 4'b1100, 4'b0000, 2'b01, 2'b00, 2'b00, 0));
    add(mk(0, JP, 0, 1, 1, 4'b0000, 4'b0000, 2'b11, 2'b00, 2'b00, 0));
    add(mk(0, JP, 0, 1, 11, 4'b1000, 4'b0000, 2'b00, 2'b10, 2'b00, 0));
    // Unknown opcode drops back to fetch
    add(mk(0, XX, 0, 1, 0, 4'b1100, 4'b0000, 2'b01, 2'b00, 2'b00, 0));
    add(mk(0, XX, 0, 1, 1, 4'b0000, 4'b0000, 2'b11, 2'b00, 2'b00, 0));
    // ADDI
    add(mk(0, AD, 0, 1, 0, 4'b1100, 4'b0000, 2'b01, 2'b00, 2'b00, 0));
    add(mk(0, AD, 0, 1, 1, 4'b0000, 4'b0000, 2'b11, 2'b00, 2'b00, 0));
`ifdef ADDI_EN
    add(mk(0, AD, 0, 1, 9, 4'b0000, 4'b0001, 2'b10, 2'b00, 2'b00, 0));
    add(mk(0, AD, 0, 1, 10, 4'b0001, 4'b0000, 2'b00, 2'b00, 2'b00, 0));
`endif
    add(mk(0, AD, 0, 0, 0, 4'b0000, 4'b0000, 2'b01, 2'b00, 2'b00, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], "tbl", i);

    // SW with mem_ready stuck low: 4 write cycles, one mem_err pulse, back to FETCH
    step(mk(0, SW, 0, 1, 0, 4'b1100, 4'b0000, 2'b01, 2'b00, 2'b00, 0), "sw_to", 0);
    step(mk(0, SW, 0, 1, 1, 4'b0000, 4'b0000, 2'b11, 2'b00, 2'b00, 0), "sw_to", 1);
    step(mk(0, SW, 0, 1, 2, 4'b0000, 4'b0001, 2'b10, 2'b00, 2'b00, 0), "sw_to", 2);
    for (int i = 0; i < 4; i++)
      step(mk(0, SW, 0, 0, 5, 4'b0010, 4'b1000, 2'b00, 2'b00, 2'b00, 0), "sw_to", 3 + i);
    step(mk(0, SW, 0, 0, 0, 4'b0000, 4'b0000, 2'b01, 2'b00, 2'b00, 1), "sw_to", 7);
    step(mk(0, SW, 0, 0, 0, 4'b0000, 4'b0000, 2'b01, 2'b00, 2'b00, 0), "sw_to", 8);

    // SW with mem_ready rising on the 4th write cycle: no mem_err
    step(mk(0, SW, 0, 1, 0, 4'b1100, 4'b0000, 2'b01, 2'b00, 2'b00, 0), "sw_ok", 0);
    step(mk(0, SW, 0, 1, 1, 4'b0000, 4'b0000, 2'b11, 2'b00, 2'b00, 0), "sw_ok", 1);
    step(mk(0, SW, 0, 1, 2, 4'b0000, 4'b0001, 2'b10, 2'b00, 2'b00, 0), "sw_ok", 2);
    for (int i = 0; i < 3; i++)
      step(mk(0, SW, 0, 0, 5, 4'b0010, 4'b1000, 2'b00, 2'b00, 2'b00, 0), "sw_ok", 3 + i);
    step(mk(0, SW, 0, 1, 5, 4'b0010, 4'b1000, 2'b00, 2'b00, 2'b00, 0), "sw_ok", 6);
    step(mk(0, SW, 0, 1, 0, 4'b1100, 4'b0000, 2'b01, 2'b00, 2'b00, 0), "sw_ok", 7);

    // LW interrupted by reset right before its writeback
    step(mk(0, LW, 0, 1, 1, 4'b0000, 4'b0000, 2'b11, 2'b00, 2'b00, 0), "lw_rst", 0);
    step(mk(0, LW, 0, 1, 2, 4'b0000, 4'b0001, 2'b10, 2'b00, 2'b00, 0), "lw_rst", 1);
    step(mk(0, LW, 0, 1, 3, 4'b0000, 4'b1000, 2'b00, 2'b00, 2'b00, 0), "lw_rst", 2);
    step(mk(1, LW, 0, 1, 0, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 0), "lw_rst", 3);
    step(mk(0, LW, 0, 1, 0, 4'b1100, 4'b0000, 2'b01, 2'b00, 2'b00, 0), "lw_rst", 4);
    step(mk(0, LW, 0, 1, 1, 4'b0000, 4'b0000, 2'b11, 2'b00, 2'b00, 0), "lw_rst", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
